// File: rtl/scope_frame_scheduler.sv
// Frame scheduler for a scope display: reads one sample per row, then streams a full
// row of RGB565 pixels (trace, grid or background) to the LT24 pixel driver.
module scope_frame_scheduler #(
  parameter int unsigned LCD_W     = 240,
  parameter int unsigned LCD_H     = 320,
  parameter int unsigned GRID_X    = 30,
  parameter int unsigned GRID_Y    = 40,
  parameter logic [15:0] TRACE_COL = 16'hFFE0,
  parameter logic [15:0] GRID_COL  = 16'h4208,
  parameter logic [15:0] BG_COL    = 16'h0000
) (
  input  logic        clock,
  input  logic        rstApp,
  input  logic        startFrame,
  output logic [8:0]  sampAddr,
  input  logic [7:0]  sampData,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic        busy,
  output logic        frameDone
);

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned COL_W = 16;
  localparam int unsigned GX_W  = (GRID_X > 1) ? $clog2(GRID_X) : 1;
  localparam int unsigned GY_W  = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;

  localparam logic [X_W-1:0]  X_LAST  = X_W'(LCD_W - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(LCD_H - 1);
  localparam logic [GX_W-1:0] GX_LAST = GX_W'(GRID_X - 1);
  localparam logic [GY_W-1:0] GY_LAST = GY_W'(GRID_Y - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    PIXEL = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT state, stateNext;

  logic [X_W-1:0]   prevS, curS, loS, hiS;
  logic [GX_W-1:0]  gridX;
  logic [GY_W-1:0]  gridY;

  logic [X_W-1:0]   xNext, prevNext, curNext, loNext, hiNext;
  logic [Y_W-1:0]   yNext, sampNext;
  logic [GX_W-1:0]  gridXNext;
  logic [GY_W-1:0]  gridYNext;
  logic [COL_W-1:0] pixNext;
  logic             writeNext, busyNext, doneNext;

  logic             accept;
  logic [X_W-1:0]   sampClamped;
  logic [X_W-1:0]   prevEff;

  assign accept      = pixelWrite & pixelReady;
  assign sampClamped = (sampData > X_LAST) ? X_LAST : sampData;
  assign prevEff     = (yAddr == '0) ? sampClamped : prevS;

  // Colour priority: trace span, then grid lines / border, then background.
  function automatic logic [COL_W-1:0] colourOf(
    input logic [X_W-1:0]  x,
    input logic [X_W-1:0]  lo,
    input logic [X_W-1:0]  hi,
    input logic [GX_W-1:0] gx,
    input logic [GY_W-1:0] gy,
    input logic [Y_W-1:0]  y
  );
    if ((x >= lo) && (x <= hi)) begin
      return TRACE_COL;
    end else if ((gx == '0) || (gy == '0) || (x == X_LAST) || (y == Y_LAST)) begin
      return GRID_COL;
    end
    return BG_COL;
  endfunction

  // State register
  always_ff @(posedge clock or posedge rstApp) begin
    if (rstApp) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    stateNext = state;
    xNext     = xAddr;
    yNext     = yAddr;
    sampNext  = sampAddr;
    prevNext  = prevS;
    curNext   = curS;
    loNext    = loS;
    hiNext    = hiS;
    gridXNext = gridX;
    gridYNext = gridY;
    pixNext   = pixelData;
    writeNext = pixelWrite;

    case (state)
      IDLE: begin
        if (startFrame) begin
          stateNext = FETCH;
          xNext     = '0;
          yNext     = '0;
          sampNext  = '0;
          gridXNext = '0;
          gridYNext = '0;
        end
      end
      FETCH: begin
        sampNext  = yAddr;
        stateNext = LATCH;
      end
      LATCH: begin
        curNext   = sampClamped;
        prevNext  = prevEff;
        loNext    = (prevEff < sampClamped) ? prevEff : sampClamped;
        hiNext    = (prevEff < sampClamped) ? sampClamped : prevEff;
        pixNext   = colourOf(xAddr, loNext, hiNext, gridX, gridY, yAddr);
        writeNext = 1'b1;
        stateNext = PIXEL;
      end
      PIXEL: begin
        if (accept) begin
          if (xAddr != X_LAST) begin
            xNext     = xAddr + X_W'(1);
            gridXNext = (gridX == GX_LAST) ? '0 : gridX + GX_W'(1);
            pixNext   = colourOf(xNext, loS, hiS, gridXNext, gridY, yAddr);
          end else begin
            writeNext = 1'b0;
            if (yAddr != Y_LAST) begin
              xNext     = '0;
              gridXNext = '0;
              yNext     = yAddr + Y_W'(1);
              gridYNext = (gridY == GY_LAST) ? '0 : gridY + GY_W'(1);
              prevNext  = curS;
              sampNext  = yNext;
              stateNext = FETCH;
            end else begin
              stateNext = DONE;
            end
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge rstApp) begin
    if (rstApp) begin
      xAddr      <= '0;
      yAddr      <= '0;
      sampAddr   <= '0;
      prevS      <= '0;
      curS       <= '0;
      loS        <= '0;
      hiS        <= '0;
      gridX      <= '0;
      gridY      <= '0;
      pixelData  <= BG_COL;
      pixelWrite <= 1'b0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      xAddr      <= xNext;
      yAddr      <= yNext;
      sampAddr   <= sampNext;
      prevS      <= prevNext;
      curS       <= curNext;
      loS        <= loNext;
      hiS        <= hiNext;
      gridX      <= gridXNext;
      gridY      <= gridYNext;
      pixelData  <= pixNext;
      pixelWrite <= writeNext;
      busy       <= busyNext;
      frameDone  <= doneNext;
    end
  end

endmodule
